// File: rtl/bin_a_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Holds the FSM state type, the add-3 correction constants and the digit-count helper.
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } estado_conv_t;

  localparam logic [3:0] BCD_UMBRAL = 4'd5;
  localparam logic [3:0] BCD_AJUSTE = 4'd3;

  // Decimal digits needed to show the largest W-bit unsigned value (2^W - 1).
  function automatic int bcd_digitos(input int w);
    longint unsigned v;
    int              d;
    v = (64'd1 << w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin_a_bcd_if.sv
// Start/busy/done handshake bundle between a controller and the converter.
interface bin_a_bcd_if #(
  parameter int W_BIN = 8,
  parameter int N_DIG = 3
);

  logic                   start;
  logic [W_BIN-1:0]       bin_in;
  logic [4*N_DIG-1:0]     bcd_out;
  logic                   busy;
  logic                   done;

  modport master (
    output start,
    output bin_in,
    input  bcd_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  bin_in,
    output bcd_out,
    output busy,
    output done
  );

endinterface

// File: rtl/bin_a_bcd_ajuste.sv
// Per-digit double-dabble correction: a digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module ajuste_bcd
  import bcd_pkg::*;
(
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  assign o_dig = (i_dig >= BCD_UMBRAL) ? (i_dig + BCD_AJUSTE) : i_dig;

endmodule

// File: rtl/bin_a_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// A conversion takes W_BIN cycles; bcd_out is only written on completion.
module bin_a_bcd
  import bcd_pkg::*;
#(
  parameter int W_BIN = 8,
  parameter int N_DIG = 3
) (
  input  logic        clk,
  input  logic        rst,
  bin_a_bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(W_BIN + 1);
  localparam int BCD_W = 4 * N_DIG;
  localparam int SH_W  = BCD_W + W_BIN;

  generate
    if (W_BIN < 1) begin : g_chk_w
      $error("bin_a_bcd: W_BIN must be at least 1");
    end
    if (N_DIG < bcd_digitos(W_BIN)) begin : g_chk_dig
      $error("bin_a_bcd: N_DIG too small to hold 2^W_BIN - 1");
    end
  endgenerate

  estado_conv_t       r_state;
  estado_conv_t       w_state_next;
  logic [BCD_W-1:0]   r_bcd_acc;
  logic [BCD_W-1:0]   w_bcd_acc_next;
  logic [W_BIN-1:0]   r_bin_sh;
  logic [W_BIN-1:0]   w_bin_sh_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [BCD_W-1:0]   r_bcd_out;
  logic [BCD_W-1:0]   w_bcd_out_next;
  logic               r_done;
  logic               w_done_next;

  logic [BCD_W-1:0]   w_adj;
  logic [SH_W-1:0]    w_cat;
  logic [SH_W-1:0]    w_sh;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIG; gi++) begin : g_dig
      ajuste_bcd u_ajuste (
        .i_dig (r_bcd_acc[4*gi +: 4]),
        .o_dig (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Correction first, then one shift of the whole {bcd, bin} register.
  assign w_cat = {w_adj, r_bin_sh};
  assign w_sh  = w_cat << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bcd_acc <= '0;
      r_bin_sh  <= '0;
      r_cnt     <= '0;
      r_bcd_out <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bcd_acc <= w_bcd_acc_next;
      r_bin_sh  <= w_bin_sh_next;
      r_cnt     <= w_cnt_next;
      r_bcd_out <= w_bcd_out_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bcd_acc_next = r_bcd_acc;
    w_bin_sh_next  = r_bin_sh;
    w_cnt_next     = r_cnt;
    w_bcd_out_next = r_bcd_out;
    w_done_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_bcd_acc_next = '0;
          w_bin_sh_next  = bus.bin_in;
          w_cnt_next     = CNT_W'(W_BIN);
          w_state_next   = CONV;
        end
      end
      CONV: begin
        w_bcd_acc_next = w_sh[SH_W-1:W_BIN];
        w_bin_sh_next  = w_sh[W_BIN-1:0];
        w_cnt_next     = r_cnt - CNT_W'(1);
        // Last bit: publish the corrected-and-shifted digits on this same edge.
        if (r_cnt == CNT_W'(1)) begin
          w_bcd_out_next = w_sh[SH_W-1:W_BIN];
          w_done_next    = 1'b1;
          w_state_next   = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.bcd_out = r_bcd_out;
  assign bus.busy    = (r_state == CONV);
  assign bus.done    = r_done;

endmodule

// File: tb/tb_bin_a_bcd.sv
// Directed bench for bin_a_bcd: default 8-bit instance plus a 4-bit/2-digit instance.
module tb_bin_a_bcd;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  bin_a_bcd_if #(.W_BIN(8), .N_DIG(3)) bus8 ();
  bin_a_bcd_if #(.W_BIN(4), .N_DIG(2)) bus4 ();

  bin_a_bcd #(.W_BIN(8), .N_DIG(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  bin_a_bcd #(.W_BIN(4), .N_DIG(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {h, t, u};
  endfunction

  // Called right after a negedge; launches one conversion and waits for done.
  task automatic run8(input logic [7:0] v, output int lat, output logic [11:0] res, output int nbusy);
    bus8.start  = 1'b1;
    bus8.bin_in = v;
    lat   = -1;
    res   = '0;
    nbusy = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      if (bus8.done) begin
        lat = i - 1;
        res = bus8.bcd_out;
        break;
      end
      if (bus8.busy) nbusy++;
    end
    $display("conv8 %0d -> %03h latency %0d", v, res, lat);
  endtask

  task automatic run4(input logic [3:0] v, output int lat, output logic [7:0] res);
    bus4.start  = 1'b1;
    bus4.bin_in = v;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus4.start = 1'b0;
      if (bus4.done) begin
        lat = i - 1;
        res = bus4.bcd_out;
        break;
      end
    end
    $display("conv4 %0d -> %02h latency %0d", v, res, lat);
  endtask

  initial begin
    int          lat;
    int          nbusy;
    int          ndone;
    int          idx;
    int          last;
    logic        prev_done;
    logic [11:0] res;
    logic [7:0]  res4;
    logic [7:0]  vals [3];
    logic [11:0] exps [3];

    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus8.start  = 1'b0;
    bus8.bin_in = '0;
    bus4.start  = 1'b0;
    bus4.bin_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("rst_bcd8", 32'(bus8.bcd_out), 32'h0);
    check_val("rst_busy8", 32'(bus8.busy), 32'h0);
    check_val("rst_done8", 32'(bus8.done), 32'h0);
    check_val("rst_bcd4", 32'(bus4.bcd_out), 32'h0);
    @(negedge clk);

    // 255 with default parameters
    run8(8'd255, lat, res, nbusy);
    check_val("v255_res", 32'(res), 32'h255);
    check_val("v255_lat", 32'(lat), 32'd8);
    check_val("v255_busy_cycles", 32'(nbusy), 32'd8);
    check_val("v255_busy_at_done", 32'(bus8.busy), 32'h0);
    @(negedge clk);
    check_val("v255_done_pulse", 32'(bus8.done), 32'h0);
    check_val("v255_hold", 32'(bus8.bcd_out), 32'h255);

    // Back to back: start raised in each done cycle
    vals = '{8'd0, 8'd99, 8'd100};
    exps = '{12'h000, 12'h099, 12'h100};
    idx = 0;
    last = 0;
    prev_done = 1'b0;
    bus8.start  = 1'b1;
    bus8.bin_in = vals[0];
    for (int i = 1; i <= 60 && idx < 3; i++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      if (prev_done) check_val("b2b_done_pulse", 32'(bus8.done), 32'h0);
      prev_done = bus8.done;
      if (bus8.done) begin
        $display("b2b %0d -> %03h at cycle %0d", vals[idx], bus8.bcd_out, i);
        check_val("b2b_res", 32'(bus8.bcd_out), 32'(exps[idx]));
        check_val("b2b_lat", 32'(i - last - 1), 32'd8);
        last = i;
        idx++;
        if (idx < 3) begin
          bus8.start  = 1'b1;
          bus8.bin_in = vals[idx];
        end
      end
    end
    check_val("b2b_count", 32'(idx), 32'd3);
    @(negedge clk);

    // Start during conversion is ignored
    bus8.start  = 1'b1;
    bus8.bin_in = 8'd37;
    ndone = 0;
    lat   = -1;
    res   = '0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      bus8.start = (i == 3);
      if (i == 3) bus8.bin_in = 8'd200;
      if (bus8.done) begin
        ndone++;
        if (lat < 0) begin
          lat = i - 1;
          res = bus8.bcd_out;
        end
      end
    end
    $display("ignore_start 37 -> %03h latency %0d dones %0d", res, lat, ndone);
    check_val("ign_res", 32'(res), 32'h037);
    check_val("ign_lat", 32'(lat), 32'd8);
    check_val("ign_ndone", 32'(ndone), 32'd1);
    check_val("ign_hold", 32'(bus8.bcd_out), 32'h037);

    // Reset in the middle of a conversion
    bus8.start  = 1'b1;
    bus8.bin_in = 8'd180;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus8.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("mid_reset busy %0d bcd %03h done %0d", bus8.busy, bus8.bcd_out, bus8.done);
    check_val("mrst_busy", 32'(bus8.busy), 32'h0);
    check_val("mrst_bcd", 32'(bus8.bcd_out), 32'h0);
    check_val("mrst_done", 32'(bus8.done), 32'h0);
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus8.done) ndone++;
    end
    check_val("mrst_no_done", 32'(ndone), 32'd0);
    run8(8'd180, lat, res, nbusy);
    check_val("v180_res", 32'(res), 32'h180);
    check_val("v180_lat", 32'(lat), 32'd8);
    @(negedge clk);

    // 4-bit / 2-digit instance
    run4(4'd15, lat, res4);
    check_val("w4_15_res", 32'(res4), 32'h15);
    check_val("w4_15_lat", 32'(lat), 32'd4);
    run4(4'd9, lat, res4);
    check_val("w4_9_res", 32'(res4), 32'h09);
    check_val("w4_9_lat", 32'(lat), 32'd4);
    @(negedge clk);

    // Full sweep against the decimal reference
    for (int v = 0; v < 256; v++) begin
      run8(8'(v), lat, res, nbusy);
      check_val("sweep_res", 32'(res), 32'(ref_bcd(v)));
      check_val("sweep_lat", 32'(lat), 32'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
